nrzi_tx: RTL and testbench

//  USB full-speed line transmitter: NRZI-encodes a serial bit stream, inserts stuff bits, generates EOP.

---
 rtl/usb_line_pkg.sv | 28 ++
 rtl/usb_bitstuff_ctr.sv | 51 +++++
 rtl/nrzi_tx.sv | 176 +++++++++++++++++
 tb/tb_nrzi_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/usb_line_pkg.sv
// usb_line_pkg
//  Shared definitions for the USB full-speed line transmitter.
//  - tx_state_t : transmitter FSM states
//  - LS_*       : pad line states packed as {DP, DM}
//  - default stuffing run length and EOP SE0 length
//  - line_of()  : maps an NRZI level (1 = J, 0 = K) onto a {DP, DM} pair
package usb_line_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    STUFF   = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_t;

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;

  localparam int STUFF_LEN_DEF    = 6;
  localparam int EOP_SE0_BITS_DEF = 2;

  function automatic logic [1:0] line_of(input logic lvl);
    return lvl ? LS_J : LS_K;
  endfunction

endpackage

// File: rtl/usb_bitstuff_ctr.sv
// usb_bitstuff_ctr
//  Counts consecutive 1 bits accepted by the transmitter and flags when the
//  bit being accepted now completes a run of STUFF_LEN ones, so the caller
//  must insert a stuff bit after it.
// Ports
//  clk        in  clock
//  rst        in  synchronous active-low reset
//  shift      in  a raw bit is accepted this cycle
//  bit_in     in  value of the accepted bit
//  clr        in  clear the run count (stuff bit sent, packet ended)
//  stuff_req  out combinational: this accepted 1 brings the run to STUFF_LEN
module usb_bitstuff_ctr
  import usb_line_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic bit_in,
  input  logic clr,
  output logic stuff_req
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  logic [CW-1:0] ones_cnt_reg;
  logic [CW-1:0] ones_cnt_next;

  // The decision uses the post-increment count: the STUFF_LEN-th 1 is sent
  // normally and the stuff bit follows it.
  assign stuff_req = shift & bit_in & (ones_cnt_reg == CW'(STUFF_LEN - 1));

  always_comb begin
    ones_cnt_next = ones_cnt_reg;
    if (clr) begin
      ones_cnt_next = '0;
    end else if (shift) begin
      ones_cnt_next = bit_in ? ones_cnt_reg + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_cnt_reg <= '0;
    end else begin
      ones_cnt_reg <= ones_cnt_next;
    end
  end

endmodule

// File: rtl/nrzi_tx.sv
// nrzi_tx
//  USB full-speed line transmitter. Takes raw packet bits (SYNC, PID, data,
//  CRC) one per bit-time strobe, NRZI-encodes them, inserts a stuff bit after
//  every STUFF_LEN consecutive 1s and finishes each packet with an EOP
//  (EOP_SE0_BITS bit times of SE0 followed by one bit time of J).
// Ports
//  clk       in  clock; all state changes on the rising edge
//  rst       in  synchronous active-low reset
//  bit_en    in  bit-time strobe (may be held high for one bit per cycle)
//  tx_valid  in  upstream bit valid
//  tx_data   in  raw bit to send
//  tx_last   in  marks the final bit of the packet (qualified by tx_valid)
//  tx_ready  out bit accepted this cycle (combinational)
//  tx_err    out one-cycle pulse on underrun abort
//  DP_out    out D+ pad level (registered)
//  DM_out    out D- pad level (registered)
//  tx_oe     out pad output enable (registered)
module nrzi_tx
  import usb_line_pkg::*;
#(
  parameter int STUFF_LEN    = STUFF_LEN_DEF,
  parameter int EOP_SE0_BITS = EOP_SE0_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic tx_valid,
  input  logic tx_data,
  input  logic tx_last,
  output logic tx_ready,
  output logic tx_err,
  output logic DP_out,
  output logic DM_out,
  output logic tx_oe
);

  localparam int EW = $clog2(EOP_SE0_BITS + 1);

  tx_state_t     state_reg, state_next;
  logic          lvl_reg, lvl_next;          // NRZI level, 1 = J
  logic          pend_eop_reg, pend_eop_next; // EOP owed after the stuff bit
  logic [EW-1:0] eop_cnt_reg, eop_cnt_next;
  logic [1:0]    line_reg, line_next;        // {DP, DM}
  logic          oe_reg, oe_next;
  logic          err_reg, err_next;

  logic transfer;
  logic lvl_enc;
  logic cnt_clr;
  logic stuff_req;

  // Nothing is accepted while reset is held.
  assign tx_ready = rst & bit_en & ((state_reg == IDLE) | (state_reg == DATA));
  assign transfer = tx_valid & tx_ready;

  // NRZI: a 0 toggles the line, a 1 holds it.
  assign lvl_enc = tx_data ? lvl_reg : ~lvl_reg;

  usb_bitstuff_ctr #(
    .STUFF_LEN (STUFF_LEN)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .shift     (transfer),
    .bit_in    (tx_data),
    .clr       (cnt_clr),
    .stuff_req (stuff_req)
  );

  always_comb begin
    state_next    = state_reg;
    lvl_next      = lvl_reg;
    pend_eop_next = pend_eop_reg;
    eop_cnt_next  = eop_cnt_reg;
    line_next     = line_reg;
    oe_next       = oe_reg;
    err_next      = 1'b0;
    cnt_clr       = 1'b0;

    if (bit_en) begin
      unique case (state_reg)
        IDLE, DATA: begin
          if (transfer) begin
            // The first bit of a packet is encoded against the idle J level.
            // A single-bit packet from IDLE follows the same rules as DATA.
            lvl_next  = lvl_enc;
            line_next = line_of(lvl_enc);
            oe_next   = 1'b1;
            if (stuff_req) begin
              // Stuffing wins over tx_last; the EOP waits for the stuff bit.
              state_next    = STUFF;
              pend_eop_next = tx_last;
            end else if (tx_last) begin
              state_next   = EOP_SE0;
              eop_cnt_next = '0;
            end else begin
              state_next = DATA;
            end
          end else if (state_reg == DATA) begin
            // Underrun: the current bit is held for this bit time, then EOP.
            err_next     = 1'b1;
            state_next   = EOP_SE0;
            eop_cnt_next = '0;
          end else begin
            lvl_next  = 1'b1;
            line_next = LS_J;
            oe_next   = 1'b0;
          end
        end

        STUFF: begin
          lvl_next      = ~lvl_reg;
          line_next     = line_of(~lvl_reg);
          cnt_clr       = 1'b1;
          pend_eop_next = 1'b0;
          eop_cnt_next  = '0;
          state_next    = pend_eop_reg ? EOP_SE0 : DATA;
        end

        EOP_SE0: begin
          line_next = LS_SE0;
          cnt_clr   = 1'b1;
          if (eop_cnt_reg == EW'(EOP_SE0_BITS - 1)) begin
            eop_cnt_next = '0;
            state_next   = EOP_J;
          end else begin
            eop_cnt_next = eop_cnt_reg + 1'b1;
          end
        end

        EOP_J: begin
          // J is driven with the pads still enabled; IDLE then drops oe.
          lvl_next   = 1'b1;
          line_next  = LS_J;
          oe_next    = 1'b1;
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end

        default: begin
          lvl_next   = 1'b1;
          line_next  = LS_J;
          oe_next    = 1'b0;
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lvl_reg      <= 1'b1;
      pend_eop_reg <= 1'b0;
      eop_cnt_reg  <= '0;
      line_reg     <= LS_J;
      oe_reg       <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lvl_reg      <= lvl_next;
      pend_eop_reg <= pend_eop_next;
      eop_cnt_reg  <= eop_cnt_next;
      line_reg     <= line_next;
      oe_reg       <= oe_next;
      err_reg      <= err_next;
    end
  end

  assign DP_out = line_reg[1];
  assign DM_out = line_reg[0];
  assign tx_oe  = oe_reg;
  assign tx_err = err_reg;

endmodule

// File: tb/tb_nrzi_tx.sv
// tb_nrzi_tx
//  Directed bench for nrzi_tx. Each step drives one bit time, checks
//  tx_ready before the edge and {DP, DM, tx_oe, tx_err} just after it.
module tb_nrzi_tx;

  logic clk = 1'b0;
  logic rst;
  logic bit_en;
  logic tx_valid;
  logic tx_data;
  logic tx_last;
  logic tx_ready;
  logic tx_err;
  logic DP_out;
  logic DM_out;
  logic tx_oe;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {DP, DM, tx_oe, tx_err}
  localparam logic [3:0] JO = 4'b1010; // J, pads enabled
  localparam logic [3:0] KO = 4'b0110; // K, pads enabled
  localparam logic [3:0] SO = 4'b0010; // SE0, pads enabled
  localparam logic [3:0] JI = 4'b1000; // idle J, pads off
  localparam logic [3:0] KE = 4'b0111; // K held, underrun pulse

  nrzi_tx dut (
    .clk      (clk),
    .rst      (rst),
    .bit_en   (bit_en),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .tx_err   (tx_err),
    .DP_out   (DP_out),
    .DM_out   (DM_out),
    .tx_oe    (tx_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // One strobed bit time.
  task automatic bstep(input logic v, input logic d, input logic l,
                       input logic exp_rdy, input logic [3:0] exp_out,
                       input string tag);
    bit_en   = 1'b1;
    tx_valid = v;
    tx_data  = d;
    tx_last  = l;
    #1;
    chk({tag, ".rdy"}, {3'b000, tx_ready}, {3'b000, exp_rdy});
    @(posedge clk);
    #1;
    chk({tag, ".out"}, {DP_out, DM_out, tx_oe, tx_err}, exp_out);
    $display("step %-10s v=%0b d=%0b l=%0b rdy=%0b DP=%0b DM=%0b oe=%0b err=%0b",
             tag, v, d, l, exp_rdy, DP_out, DM_out, tx_oe, tx_err);
  endtask

  // One clock without a strobe: nothing may change, nothing accepted.
  task automatic gap(input logic [3:0] exp_out, input string tag);
    bit_en   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 1'b0;
    tx_last  = 1'b0;
    #1;
    chk({tag, ".rdy"}, {3'b000, tx_ready}, 4'b0000);
    @(posedge clk);
    #1;
    chk({tag, ".out"}, {DP_out, DM_out, tx_oe, tx_err}, exp_out);
    $display("gap  %-10s DP=%0b DM=%0b oe=%0b err=%0b", tag, DP_out, DM_out, tx_oe, tx_err);
  endtask

  initial begin
    rst      = 1'b0;
    bit_en   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 1'b0;
    tx_last  = 1'b0;

    // Reset held two cycles with bit_en high: idle J, nothing accepted.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst.rdy", {3'b000, tx_ready}, 4'b0000);
      @(posedge clk);
      #1;
      chk("rst.out", {DP_out, DM_out, tx_oe, tx_err}, JI);
      $display("rst  cycle %0d DP=%0b DM=%0b oe=%0b", i, DP_out, DM_out, tx_oe);
    end
    rst = 1'b1;

    // Packet 1: SYNC 0000_0001 -> K J K J K J K K.
    bstep(1, 0, 0, 1, KO, "sync0");
    bstep(1, 0, 0, 1, JO, "sync1");
    bstep(1, 0, 0, 1, KO, "sync2");
    bstep(1, 0, 0, 1, JO, "sync3");
    bstep(1, 0, 0, 1, KO, "sync4");
    bstep(1, 0, 0, 1, JO, "sync5");
    bstep(1, 0, 0, 1, KO, "sync6");
    bstep(1, 1, 0, 1, KO, "sync7");
    // SYNC's final 1 starts the run; five more 1s make six, all at K.
    for (int i = 0; i < 5; i++) bstep(1, 1, 0, 1, KO, "ones_a");
    // Stuff bit: toggle to J, the offered bit is not taken.
    bstep(1, 1, 0, 0, JO, "stuff_a");
    // Run restarts at zero: six more 1s hold J, then a second stuff to K.
    for (int i = 0; i < 6; i++) bstep(1, 1, 0, 1, JO, "ones_b");
    bstep(1, 0, 0, 0, KO, "stuff_b");
    // Final bit is a 0 with tx_last: K -> J, then EOP.
    bstep(1, 0, 1, 1, JO, "last0");
    bstep(1, 1, 0, 0, SO, "se0_a");
    bstep(1, 1, 0, 0, SO, "se0_b");
    bstep(0, 0, 0, 0, JO, "eop_j");
    bstep(0, 0, 0, 1, JI, "idle1");

    // Packet 2: underrun after two bits.
    bstep(1, 0, 0, 1, KO, "u_bit0");
    bstep(1, 1, 0, 1, KO, "u_bit1");
    bstep(0, 0, 1, 1, KE, "underrun");
    bstep(0, 0, 0, 0, SO, "u_se0_a");
    bstep(0, 0, 0, 0, SO, "u_se0_b");
    bstep(0, 0, 0, 0, JO, "u_eop_j");
    // tx_last without tx_valid in IDLE is ignored.
    bstep(0, 0, 1, 1, JI, "idle2");

    // Packet 3: tx_last on the sixth 1 -> stuff bit precedes EOP.
    for (int i = 0; i < 5; i++) bstep(1, 1, 0, 1, JO, "p3_ones");
    bstep(1, 1, 1, 1, JO, "p3_last6");
    bstep(1, 1, 0, 0, KO, "p3_stuff");
    bstep(1, 0, 0, 0, SO, "p3_se0_a");
    bstep(1, 0, 0, 0, SO, "p3_se0_b");
    bstep(0, 0, 0, 0, JO, "p3_eop_j");
    bstep(0, 0, 0, 1, JI, "idle3");

    // Sparse strobe: one bit_en every 4th clock; outputs hold in between,
    // and tx_valid low without a strobe is not an underrun.
    bstep(1, 0, 0, 1, KO, "sp_bit0");
    for (int i = 0; i < 3; i++) gap(KO, "sp_hold0");
    bstep(1, 1, 0, 1, KO, "sp_bit1");
    for (int i = 0; i < 3; i++) gap(KO, "sp_hold1");
    bstep(1, 0, 0, 1, JO, "sp_bit2");
    gap(JO, "sp_hold2");

    // Reset mid-packet with no strobe: back to idle J, no EOP, no error.
    rst    = 1'b0;
    bit_en = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid.out", {DP_out, DM_out, tx_oe, tx_err}, JI);
    $display("rst  mid-packet DP=%0b DM=%0b oe=%0b err=%0b", DP_out, DM_out, tx_oe, tx_err);
    rst = 1'b1;
    gap(JI, "post_rst");
    bstep(0, 0, 0, 1, JI, "post_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
